// File: rtl/task_page_allocator.sv
// task_page_allocator
//   Tracks occupancy of every (PE, page) slot in the mesh. Allocation requests are granted
//   by a round-robin scan over PEs, one PE per cycle. The lowest free page of the first PE
//   with room is returned. Frees are single-cycle and always accepted.
//
// Ports
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   alloc_req_i   allocation request, level, held until alloc_ack_o
//   alloc_ack_o   one-cycle pulse; alloc_addr_o/alloc_page_o/alloc_fail_o valid this cycle
//   alloc_addr_o  Hermes address {x, y} of the granted PE
//   alloc_page_o  granted page index
//   alloc_fail_o  no free slot was found
//   free_valid_i  one-cycle free command
//   free_addr_i   Hermes address of the slot to free
//   free_page_i   page index of the slot to free
//   free_err_o    pulse one cycle after a rejected free
//   free_cnt_o    number of free slots
module task_page_allocator #(
  parameter int unsigned N_PE_X       = 2,
  parameter int unsigned N_PE_Y       = 2,
  parameter int unsigned TASKS_PER_PE = 1,
  localparam int unsigned N_PE        = N_PE_X * N_PE_Y,
  localparam int unsigned PW          = (TASKS_PER_PE > 1) ? $clog2(TASKS_PER_PE) : 1,
  localparam int unsigned CW          = $clog2(N_PE * TASKS_PER_PE + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          alloc_req_i,
  output logic          alloc_ack_o,
  output logic [15:0]   alloc_addr_o,
  output logic [PW-1:0] alloc_page_o,
  output logic          alloc_fail_o,
  input  logic          free_valid_i,
  input  logic [15:0]   free_addr_i,
  input  logic [PW-1:0] free_page_i,
  output logic          free_err_o,
  output logic [CW-1:0] free_cnt_o
);

  localparam int unsigned NSLOT = N_PE * TASKS_PER_PE;
  localparam int unsigned IW    = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int unsigned SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(NSLOT);

  typedef enum logic [1:0] {StIdle, StScan, StResp} state_e;

  state_e               r_state, w_state_d;
  logic [NSLOT-1:0]     r_occ, w_occ_d;
  logic [IW-1:0]        r_rr_ptr, w_rr_ptr_d;
  logic [IW-1:0]        r_idx, w_idx_d;
  logic [IW-1:0]        r_step, w_step_d;
  logic                 r_ack, w_ack_d;
  logic [15:0]          r_addr, w_addr_d;
  logic [PW-1:0]        r_page, w_page_d;
  logic                 r_fail, w_fail_d;
  logic                 r_free_err, w_free_err_d;
  logic [CW-1:0]        r_free_cnt, w_free_cnt_d;

  // Scan-side decode of the PE under examination
  logic [TASKS_PER_PE-1:0] w_pe_occ;
  logic                    w_found;
  logic [PW-1:0]           w_sel_page;
  logic [7:0]              w_scan_x, w_scan_y;
  logic [IW-1:0]           w_idx_inc;
  logic                    w_grant;

  always_comb begin
    w_pe_occ   = '0;
    w_found    = 1'b0;
    w_sel_page = '0;
    for (int p = 0; p < int'(TASKS_PER_PE); p++) begin
      w_pe_occ[p] = r_occ[SW'(int'(r_idx) * TASKS_PER_PE + p)];
    end
    // Descending loop so the last assignment wins with the lowest free page
    for (int p = int'(TASKS_PER_PE) - 1; p >= 0; p--) begin
      if (!w_pe_occ[p]) begin
        w_found    = 1'b1;
        w_sel_page = PW'(p);
      end
    end
  end

  assign w_scan_x  = 8'(int'(r_idx) % N_PE_X);
  assign w_scan_y  = 8'(int'(r_idx) / N_PE_X);
  assign w_idx_inc = (r_idx == IW'(N_PE - 1)) ? '0 : r_idx + 1'b1;

  // Free-side decode
  logic [7:0]    w_fx, w_fy;
  logic          w_free_in_range;
  logic [SW-1:0] w_free_slot;
  logic          w_free_ok;

  assign w_fx            = free_addr_i[15:8];
  assign w_fy            = free_addr_i[7:0];
  assign w_free_in_range = (32'(w_fx) < N_PE_X) && (32'(w_fy) < N_PE_Y) &&
                           (32'(free_page_i) < TASKS_PER_PE);
  assign w_free_slot     = SW'((32'(w_fy) * N_PE_X + 32'(w_fx)) * TASKS_PER_PE +
                               32'(free_page_i));
  // Guard the lookup so an out-of-range address never indexes the bitmap
  assign w_free_ok       = free_valid_i && w_free_in_range && r_occ[w_free_slot];

  // Next-state and registered outputs
  always_comb begin
    w_state_d  = r_state;
    w_idx_d    = r_idx;
    w_step_d   = r_step;
    w_rr_ptr_d = r_rr_ptr;
    w_ack_d    = 1'b0;
    w_addr_d   = r_addr;
    w_page_d   = r_page;
    w_fail_d   = r_fail;
    w_grant    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (alloc_req_i) begin
          w_idx_d   = r_rr_ptr;
          w_step_d  = '0;
          w_state_d = StScan;
        end
      end
      StScan: begin
        if (w_found) begin
          w_grant    = 1'b1;
          w_addr_d   = {w_scan_x, w_scan_y};
          w_page_d   = w_sel_page;
          w_fail_d   = 1'b0;
          w_rr_ptr_d = w_idx_inc;
          w_ack_d    = 1'b1;
          w_state_d  = StResp;
        end else if (r_step == IW'(N_PE - 1)) begin
          w_fail_d  = 1'b1;
          w_ack_d   = 1'b1;
          w_state_d = StResp;
        end else begin
          w_idx_d  = w_idx_inc;
          w_step_d = r_step + 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Alloc only sets a free bit and free only clears an occupied bit, so they never collide
  always_comb begin
    w_occ_d = r_occ;
    if (w_grant) begin
      w_occ_d[SW'(int'(r_idx) * TASKS_PER_PE + int'(w_sel_page))] = 1'b1;
    end
    if (w_free_ok) begin
      w_occ_d[w_free_slot] = 1'b0;
    end
  end

  always_comb begin
    w_free_cnt_d = r_free_cnt;
    unique case ({w_grant, w_free_ok})
      2'b10:   if (r_free_cnt != '0)      w_free_cnt_d = r_free_cnt - 1'b1;
      2'b01:   if (r_free_cnt != CNT_MAX) w_free_cnt_d = r_free_cnt + 1'b1;
      default: w_free_cnt_d = r_free_cnt;
    endcase
    w_free_err_d = free_valid_i && !w_free_ok;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_occ      <= '0;
      r_rr_ptr   <= '0;
      r_idx      <= '0;
      r_step     <= '0;
      r_ack      <= 1'b0;
      r_addr     <= '0;
      r_page     <= '0;
      r_fail     <= 1'b0;
      r_free_err <= 1'b0;
      r_free_cnt <= CNT_MAX;
    end else begin
      r_state    <= w_state_d;
      r_occ      <= w_occ_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_idx      <= w_idx_d;
      r_step     <= w_step_d;
      r_ack      <= w_ack_d;
      r_addr     <= w_addr_d;
      r_page     <= w_page_d;
      r_fail     <= w_fail_d;
      r_free_err <= w_free_err_d;
      r_free_cnt <= w_free_cnt_d;
    end
  end

  assign alloc_ack_o  = r_ack;
  assign alloc_addr_o = r_addr;
  assign alloc_page_o = r_page;
  assign alloc_fail_o = r_fail;
  assign free_err_o   = r_free_err;
  assign free_cnt_o   = r_free_cnt;

endmodule

// File: tb/tb_task_page_allocator.sv
// Bench for task_page_allocator: one default 2x2/1-page instance (A) and one 2x2/2-page
// instance (B). Table-driven alloc/free vectors plus hand-written sequences for the
// free-during-scan overlap and reset in the middle of a scan.
module tb_task_page_allocator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_req, a_ack, a_fail, a_fvalid, a_err;
  logic [15:0] a_addr, a_faddr;
  logic [0:0]  a_page, a_fpage;
  logic [2:0]  a_cnt;

  // Instance B: two pages per PE
  logic        b_req, b_ack, b_fail, b_fvalid, b_err;
  logic [15:0] b_addr, b_faddr;
  logic [0:0]  b_page, b_fpage;
  logic [3:0]  b_cnt;

  task_page_allocator u_dut_a (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_req_i  (a_req),
    .alloc_ack_o  (a_ack),
    .alloc_addr_o (a_addr),
    .alloc_page_o (a_page),
    .alloc_fail_o (a_fail),
    .free_valid_i (a_fvalid),
    .free_addr_i  (a_faddr),
    .free_page_i  (a_fpage),
    .free_err_o   (a_err),
    .free_cnt_o   (a_cnt)
  );

  task_page_allocator #(
    .N_PE_X       (2),
    .N_PE_Y       (2),
    .TASKS_PER_PE (2)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_req_i  (b_req),
    .alloc_ack_o  (b_ack),
    .alloc_addr_o (b_addr),
    .alloc_page_o (b_page),
    .alloc_fail_o (b_fail),
    .free_valid_i (b_fvalid),
    .free_addr_i  (b_faddr),
    .free_page_i  (b_fpage),
    .free_err_o   (b_err),
    .free_cnt_o   (b_cnt)
  );

  // Selected-instance view
  bit          sel = 1'b0;
  logic        m_ack, m_fail, m_err;
  logic [15:0] m_addr;
  logic        m_page;
  logic [3:0]  m_cnt;
  assign m_ack  = sel ? b_ack  : a_ack;
  assign m_fail = sel ? b_fail : a_fail;
  assign m_err  = sel ? b_err  : a_err;
  assign m_addr = sel ? b_addr : a_addr;
  assign m_page = sel ? b_page[0] : a_page[0];
  assign m_cnt  = sel ? b_cnt  : {1'b0, a_cnt};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic v);
    if (sel) b_req = v;
    else     a_req = v;
  endtask

  task automatic set_free(input logic v, input logic [15:0] addr, input logic page);
    if (sel) begin
      b_fvalid = v; b_faddr = addr; b_fpage = page;
    end else begin
      a_fvalid = v; a_faddr = addr; a_fpage = page;
    end
  endtask

  // Latency = posedges from raising the request until the ack is seen
  task automatic do_alloc(input string tag, input logic [15:0] ea, input logic ep,
                          input bit ef, input int elat, input int ecnt);
    int lat = 0;
    bit got = 1'b0;
    @(negedge clk);
    set_req(1'b1);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (m_ack) got = 1'b1;
    end
    set_req(1'b0);
    if (!got) begin
      chk({tag, "_ack_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_fail"}, int'(m_fail), int'(ef));
    if (!ef) begin
      chk({tag, "_addr"}, int'(m_addr), int'(ea));
      chk({tag, "_page"}, int'(m_page), int'(ep));
    end
    chk({tag, "_cnt"}, int'(m_cnt), ecnt);
    @(negedge clk);
    chk({tag, "_ack_pulse"}, int'(m_ack), 0);
  endtask

  task automatic do_free(input string tag, input logic [15:0] addr, input logic page,
                         input bit eerr, input int ecnt);
    @(negedge clk);
    set_free(1'b1, addr, page);
    @(posedge clk);
    @(negedge clk);
    set_free(1'b0, 16'h0, 1'b0);
    chk({tag, "_err"}, int'(m_err), int'(eerr));
    chk({tag, "_cnt"}, int'(m_cnt), ecnt);
  endtask

  typedef struct {
    bit          is_free;
    logic [15:0] addr;
    logic        page;
    bit          exp_fail;
    int          exp_lat;
    int          exp_cnt;
    bit          exp_err;
  } vec_t;

  function automatic vec_t va(logic [15:0] a, logic p, bit f, int lat, int cnt);
    vec_t v;
    v.is_free = 1'b0; v.addr = a; v.page = p; v.exp_fail = f;
    v.exp_lat = lat;  v.exp_cnt = cnt; v.exp_err = 1'b0;
    return v;
  endfunction

  function automatic vec_t vf(logic [15:0] a, logic p, bit e, int cnt);
    vec_t v;
    v.is_free = 1'b1; v.addr = a; v.page = p; v.exp_fail = 1'b0;
    v.exp_lat = 0;    v.exp_cnt = cnt; v.exp_err = e;
    return v;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    if (v.is_free) do_free(tag, v.addr, v.page, v.exp_err, v.exp_cnt);
    else           do_alloc(tag, v.addr, v.page, v.exp_fail, v.exp_lat, v.exp_cnt);
  endtask

  vec_t tab_a[16];
  vec_t tab_b[8];

  initial begin
    int  lat;
    bit  got;

    // Instance A, default 2x2, one page per PE
    tab_a[0]  = va(16'h0000, 1'b0, 1'b0, 2, 3);
    tab_a[1]  = va(16'h0100, 1'b0, 1'b0, 2, 2);
    tab_a[2]  = va(16'h0001, 1'b0, 1'b0, 2, 1);
    tab_a[3]  = va(16'h0101, 1'b0, 1'b0, 2, 0);
    tab_a[4]  = va(16'h0000, 1'b0, 1'b1, 5, 0);  // full: fail after N_PE+1
    tab_a[5]  = vf(16'h0100, 1'b0, 1'b0, 1);
    tab_a[6]  = va(16'h0100, 1'b0, 1'b0, 3, 0);  // rr_ptr stayed 0, PE0 busy
    tab_a[7]  = vf(16'h0100, 1'b0, 1'b0, 1);
    tab_a[8]  = vf(16'h0100, 1'b0, 1'b1, 1);     // double free
    tab_a[9]  = vf(16'h0200, 1'b0, 1'b1, 1);     // x out of range
    tab_a[10] = vf(16'h0000, 1'b1, 1'b1, 1);     // page out of range
    tab_a[11] = va(16'h0100, 1'b0, 1'b0, 5, 0);  // rr=2, wraps to PE1 on 4th scan
    tab_a[12] = vf(16'h0001, 1'b0, 1'b0, 1);
    tab_a[13] = vf(16'h0000, 1'b0, 1'b0, 2);
    tab_a[14] = va(16'h0001, 1'b0, 1'b0, 2, 1);
    tab_a[15] = va(16'h0000, 1'b0, 1'b0, 3, 0);  // rr=3: PE3 busy, PE0 free

    // Instance B, two pages per PE
    tab_b[0] = va(16'h0000, 1'b0, 1'b0, 2, 7);
    tab_b[1] = va(16'h0100, 1'b0, 1'b0, 2, 6);
    tab_b[2] = va(16'h0001, 1'b0, 1'b0, 2, 5);
    tab_b[3] = va(16'h0101, 1'b0, 1'b0, 2, 4);
    tab_b[4] = va(16'h0000, 1'b1, 1'b0, 2, 3);
    tab_b[5] = va(16'h0100, 1'b1, 1'b0, 2, 2);
    tab_b[6] = va(16'h0001, 1'b1, 1'b0, 2, 1);
    tab_b[7] = va(16'h0101, 1'b1, 1'b0, 2, 0);

    a_req = 1'b0; a_fvalid = 1'b0; a_faddr = '0; a_fpage = '0;
    b_req = 1'b0; b_fvalid = 1'b0; b_faddr = '0; b_fpage = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_a_cnt", int'(a_cnt), 4);
    chk("rst_a_ack", int'(a_ack), 0);
    chk("rst_a_addr", int'(a_addr), 0);
    chk("rst_a_err", int'(a_err), 0);
    chk("rst_b_cnt", int'(b_cnt), 8);

    sel = 1'b0;
    for (int i = 0; i < 16; i++) run_vec($sformatf("a%0d", i), tab_a[i]);

    sel = 1'b1;
    for (int i = 0; i < 8; i++) run_vec($sformatf("b%0d", i), tab_b[i]);

    // Free (0x0000,1) during the scan cycle that examines the full PE0: scan skips it
    @(negedge clk);
    b_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_fvalid = 1'b1; b_faddr = 16'h0000; b_fpage = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_fvalid = 1'b0;
    chk("ovl_free_err", int'(b_err), 0);
    chk("ovl_free_cnt", int'(b_cnt), 1);
    lat = 2;
    got = b_ack;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (b_ack) got = 1'b1;
    end
    b_req = 1'b0;
    chk("ovl_ack_seen", int'(got), 1);
    chk("ovl_lat", lat, 5);
    chk("ovl_fail", int'(b_fail), 1);
    do_alloc("ovl_next", 16'h0000, 1'b1, 1'b0, 2, 0);

    // Reset in the middle of a scan with A half full
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    do_alloc("r6_0", 16'h0000, 1'b0, 1'b0, 2, 3);
    do_alloc("r6_1", 16'h0100, 1'b0, 1'b0, 2, 2);
    @(negedge clk);
    a_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    a_req = 1'b0;
    #1;
    chk("r6_ack", int'(a_ack), 0);
    chk("r6_addr", int'(a_addr), 0);
    chk("r6_page", int'(a_page), 0);
    chk("r6_fail", int'(a_fail), 0);
    chk("r6_err", int'(a_err), 0);
    chk("r6_cnt", int'(a_cnt), 4);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("r6_no_ack", int'(a_ack), 0);
    do_alloc("r6_next", 16'h0000, 1'b0, 1'b0, 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
